// File: rtl/slow_adc_pkg.sv
// Shared types, widths and the rounding helper for the slow-ADC boxcar averager.
package slow_adc_pkg;

  localparam int unsigned N_SADC_CH     = 16;
  localparam int unsigned SADC_W        = 16;
  localparam int unsigned MAX_LOG2_NAVG = 8;
  localparam int unsigned ACC_MAX_W     = SADC_W + MAX_LOG2_NAVG;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DUMP = 2'd2
  } sadc_state_e;

  // Round-half-up average: (acc + 2^(l-1)) >>> l, truncated to the sample width.
  function automatic logic signed [SADC_W-1:0] avg_round(
    input logic signed [ACC_MAX_W-1:0] acc,
    input int unsigned                 l
  );
    logic signed [ACC_MAX_W-1:0] rnd;
    logic signed [ACC_MAX_W-1:0] sum;
    rnd = '0;
    if (l != 0) begin
      rnd = ACC_MAX_W'(1) << (l - 1);
    end
    sum = acc + rnd;
    return SADC_W'(sum >>> l);
  endfunction

endpackage

// File: rtl/slow_adc_averager.sv
// Boxcar decimator: snapshots 16 slow-ADC channels per frame, accumulates 2^LOG2_NAVG
// frames through one shared adder, then dumps rounded averages one channel per cycle.
module slow_adc_averager
  import slow_adc_pkg::*;
#(
  parameter int unsigned LOG2_NAVG = 4,
  parameter int unsigned N_CH      = N_SADC_CH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_stb,
  input  logic signed [SADC_W-1:0] s_in_0,
  input  logic signed [SADC_W-1:0] s_in_1,
  input  logic signed [SADC_W-1:0] s_in_2,
  input  logic signed [SADC_W-1:0] s_in_3,
  input  logic signed [SADC_W-1:0] s_in_4,
  input  logic signed [SADC_W-1:0] s_in_5,
  input  logic signed [SADC_W-1:0] s_in_6,
  input  logic signed [SADC_W-1:0] s_in_7,
  input  logic signed [SADC_W-1:0] s_in_8,
  input  logic signed [SADC_W-1:0] s_in_9,
  input  logic signed [SADC_W-1:0] s_in_10,
  input  logic signed [SADC_W-1:0] s_in_11,
  input  logic signed [SADC_W-1:0] s_in_12,
  input  logic signed [SADC_W-1:0] s_in_13,
  input  logic signed [SADC_W-1:0] s_in_14,
  input  logic signed [SADC_W-1:0] s_in_15,
  output logic signed [SADC_W-1:0] s_avg_0,
  output logic signed [SADC_W-1:0] s_avg_1,
  output logic signed [SADC_W-1:0] s_avg_2,
  output logic signed [SADC_W-1:0] s_avg_3,
  output logic signed [SADC_W-1:0] s_avg_4,
  output logic signed [SADC_W-1:0] s_avg_5,
  output logic signed [SADC_W-1:0] s_avg_6,
  output logic signed [SADC_W-1:0] s_avg_7,
  output logic signed [SADC_W-1:0] s_avg_8,
  output logic signed [SADC_W-1:0] s_avg_9,
  output logic signed [SADC_W-1:0] s_avg_10,
  output logic signed [SADC_W-1:0] s_avg_11,
  output logic signed [SADC_W-1:0] s_avg_12,
  output logic signed [SADC_W-1:0] s_avg_13,
  output logic signed [SADC_W-1:0] s_avg_14,
  output logic signed [SADC_W-1:0] s_avg_15,
  output logic                     avg_valid,
  output logic                     busy,
  output logic                     overrun
);

  localparam int unsigned ACC_W = SADC_W + LOG2_NAVG;
  localparam int unsigned FC_W  = (LOG2_NAVG > 0) ? LOG2_NAVG : 1;
  localparam int unsigned IDX_W = $clog2(N_CH);

  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'((1 << LOG2_NAVG) - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CH - 1);

  sadc_state_e state_q, state_d;

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [FC_W-1:0]  fcnt_q, fcnt_d;

  logic signed [ACC_W-1:0]  acc_q  [N_CH];
  logic signed [ACC_W-1:0]  acc_d  [N_CH];
  logic signed [SADC_W-1:0] snap_q [N_CH];
  logic signed [SADC_W-1:0] snap_d [N_CH];
  logic signed [SADC_W-1:0] avg_q  [N_CH];
  logic signed [SADC_W-1:0] avg_d  [N_CH];
  logic signed [SADC_W-1:0] s_in_a [N_CH];

  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [SADC_W-1:0] avg_rnd;

  logic dump_done_q, dump_done_d;
  logic avg_valid_q;
  logic busy_q;
  logic overrun_q, overrun_d;

  assign s_in_a[0]  = s_in_0;
  assign s_in_a[1]  = s_in_1;
  assign s_in_a[2]  = s_in_2;
  assign s_in_a[3]  = s_in_3;
  assign s_in_a[4]  = s_in_4;
  assign s_in_a[5]  = s_in_5;
  assign s_in_a[6]  = s_in_6;
  assign s_in_a[7]  = s_in_7;
  assign s_in_a[8]  = s_in_8;
  assign s_in_a[9]  = s_in_9;
  assign s_in_a[10] = s_in_10;
  assign s_in_a[11] = s_in_11;
  assign s_in_a[12] = s_in_12;
  assign s_in_a[13] = s_in_13;
  assign s_in_a[14] = s_in_14;
  assign s_in_a[15] = s_in_15;

  // Single shared adder and rounder, both steered by idx_q.
  assign acc_sum = acc_q[idx_q] + ACC_W'(snap_q[idx_q]);
  assign avg_rnd = avg_round(ACC_MAX_W'(acc_q[idx_q]), LOG2_NAVG);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    fcnt_d      = fcnt_q;
    acc_d       = acc_q;
    snap_d      = snap_q;
    avg_d       = avg_q;
    dump_done_d = 1'b0;
    overrun_d   = overrun_q | (frame_stb & (state_q != IDLE));

    unique case (state_q)
      IDLE: begin
        if (frame_stb) begin
          snap_d  = s_in_a;
          idx_d   = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        acc_d[idx_q] = acc_sum;
        idx_d        = idx_q + IDX_W'(1);
        if (idx_q == IDX_LAST) begin
          idx_d = '0;
          if (fcnt_q == FC_LAST) begin
            fcnt_d  = '0;
            state_d = DUMP;
          end else begin
            fcnt_d  = fcnt_q + FC_W'(1);
            state_d = IDLE;
          end
        end
      end
      DUMP: begin
        avg_d[idx_q] = avg_rnd;
        acc_d[idx_q] = '0;
        idx_d        = idx_q + IDX_W'(1);
        if (idx_q == IDX_LAST) begin
          idx_d       = '0;
          state_d     = IDLE;
          dump_done_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // avg_valid trails the last channel write by one cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      fcnt_q      <= '0;
      dump_done_q <= 1'b0;
      avg_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < int'(N_CH); i++) begin
        acc_q[i]  <= '0;
        snap_q[i] <= '0;
        avg_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      fcnt_q      <= fcnt_d;
      acc_q       <= acc_d;
      snap_q      <= snap_d;
      avg_q       <= avg_d;
      dump_done_q <= dump_done_d;
      avg_valid_q <= dump_done_q;
      busy_q      <= (state_d != IDLE);
      overrun_q   <= overrun_d;
    end
  end

  assign s_avg_0   = avg_q[0];
  assign s_avg_1   = avg_q[1];
  assign s_avg_2   = avg_q[2];
  assign s_avg_3   = avg_q[3];
  assign s_avg_4   = avg_q[4];
  assign s_avg_5   = avg_q[5];
  assign s_avg_6   = avg_q[6];
  assign s_avg_7   = avg_q[7];
  assign s_avg_8   = avg_q[8];
  assign s_avg_9   = avg_q[9];
  assign s_avg_10  = avg_q[10];
  assign s_avg_11  = avg_q[11];
  assign s_avg_12  = avg_q[12];
  assign s_avg_13  = avg_q[13];
  assign s_avg_14  = avg_q[14];
  assign s_avg_15  = avg_q[15];
  assign avg_valid = avg_valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule
